// File: rtl/cnt_ud_tc.sv
// rtl/cnt_ud_tc.sv - loadable up/down binary counter with terminal-count detect and carry-out pulse
//
// Optional build macro: CNT_UD_TC_SCLR_EN (adds the SCLR synchronous clear input)
//
// Parameters:
//   WIDTH   counter width in bits (2..16)
//   ONESHOT 0 = free-running wrap, 1 = stop at terminal until LD
//   INIT    value forced into Q by CD (and SCLR when built in)
//
// Ports:
//   CK   in   rising-edge clock
//   CD   in   asynchronous clear, active-high
//   SP   in   count enable
//   LD   in   synchronous parallel load (beats SP)
//   SCLR in   synchronous clear, only with CNT_UD_TC_SCLR_EN (beats LD and SP)
//   UP   in   direction, 1 = increment, 0 = decrement
//   D    in   parallel load data
//   Q    out  registered counter value
//   TC   out  terminal count, combinational from Q, UP and state
//   CO   out  registered one-cycle pulse after a terminal step
//   RUN  out  high while the state machine is in COUNT
module cnt_ud_tc #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ONESHOT = 0,
  parameter int unsigned INIT    = 0
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic             LD,
`ifdef CNT_UD_TC_SCLR_EN
  input  logic             SCLR,
`endif
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO,
  output logic             RUN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  // One-shot parts wait in IDLE for their first load; free-running parts
  // live permanently in COUNT.
  localparam state_t RST_STATE = (ONESHOT != 0) ? S_IDLE : S_COUNT;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] term;
  logic             tc;
  logic             sclr;

`ifdef CNT_UD_TC_SCLR_EN
  assign sclr = SCLR;
`else
  assign sclr = 1'b0;
`endif

  // Terminal value tracks UP directly so a direction flip moves TC
  // in the same cycle.
  assign term = UP ? ONES_V : ZERO_V;
  assign tc   = (q_q == term) && (state_q == S_COUNT);

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q <= RST_STATE;
      q_q     <= INIT_V;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      co_q    <= co_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    co_d    = 1'b0;
    if (sclr) begin
      state_d = RST_STATE;
      q_d     = INIT_V;
    end else if (LD) begin
      state_d = S_COUNT;
      q_d     = D;
    end else if ((state_q == S_COUNT) && SP) begin
      // A step taken at terminal is the wrap step and raises CO next cycle.
      co_d = tc;
      if (tc && (ONESHOT != 0)) begin
        // One-shot parks on the terminal value instead of wrapping.
        state_d = S_DONE;
      end else if (UP) begin
        q_d = q_q + ONE_V;
      end else begin
        q_d = q_q - ONE_V;
      end
    end
  end

  assign Q   = q_q;
  assign TC  = tc;
  assign CO  = co_q;
  assign RUN = (state_q == S_COUNT);

endmodule

// File: tb/tb_cnt_ud_tc.sv
// tb/tb_cnt_ud_tc.sv - directed self-checking bench for cnt_ud_tc (free-running and one-shot instances)
module tb_cnt_ud_tc;

  logic       ck;
  logic       cd_a, sp_a, ld_a, up_a, sclr_a;
  logic [3:0] d_a, q_a;
  logic       tc_a, co_a, run_a;
  logic       cd_b, sp_b, ld_b, up_b, sclr_b;
  logic [3:0] d_b, q_b;
  logic       tc_b, co_b, run_b;

  int checks = 0;
  int errors = 0;

  cnt_ud_tc #(.WIDTH(4), .ONESHOT(0), .INIT(0)) dut_a (
    .CK(ck), .CD(cd_a), .SP(sp_a), .LD(ld_a),
`ifdef CNT_UD_TC_SCLR_EN
    .SCLR(sclr_a),
`endif
    .UP(up_a), .D(d_a), .Q(q_a), .TC(tc_a), .CO(co_a), .RUN(run_a)
  );

  cnt_ud_tc #(.WIDTH(4), .ONESHOT(1), .INIT(0)) dut_b (
    .CK(ck), .CD(cd_b), .SP(sp_b), .LD(ld_b),
`ifdef CNT_UD_TC_SCLR_EN
    .SCLR(sclr_b),
`endif
    .UP(up_b), .D(d_b), .Q(q_b), .TC(tc_b), .CO(co_b), .RUN(run_b)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    cd_a = 1'b1; cd_b = 1'b1;
    #12;
    checks++; if (q_a !== 4'h0) begin errors++; $display("FAIL reset_q_a got %h exp %h", q_a, 4'h0); end
    checks++; if (co_a !== 1'b0) begin errors++; $display("FAIL reset_co_a got %b exp 0", co_a); end
    checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL reset_run_a got %b exp 1", run_a); end
    checks++; if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc_a_up got %b exp 0", tc_a); end
    up_a = 1'b0; #1;
    checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL reset_tc_a_down got %b exp 1", tc_a); end
    up_a = 1'b1;
    checks++; if (run_b !== 1'b0) begin errors++; $display("FAIL reset_run_b got %b exp 0", run_b); end
    checks++; if (q_b !== 4'h0) begin errors++; $display("FAIL reset_q_b got %h exp %h", q_b, 4'h0); end
    @(negedge ck);
    cd_a = 1'b0; cd_b = 1'b0;
    tick();
  endtask

  task automatic test_async_clear();
    ld_a = 1'b1; d_a = 4'h7; sp_a = 1'b0; up_a = 1'b1;
    tick();
    ld_a = 1'b0;
    checks++; if (q_a !== 4'h7) begin errors++; $display("FAIL acl_load got %h exp %h", q_a, 4'h7); end
    #3 cd_a = 1'b1;
    #1;
    checks++; if (q_a !== 4'h0) begin errors++; $display("FAIL acl_q got %h exp %h", q_a, 4'h0); end
    checks++; if (co_a !== 1'b0 || run_a !== 1'b1) begin errors++; $display("FAIL acl_co_run got %b%b exp 01", co_a, run_a); end
    @(negedge ck);
    cd_a = 1'b0;
  endtask

  task automatic test_up_wrap();
    ld_a = 1'b1; d_a = 4'hD; sp_a = 1'b0; up_a = 1'b1;
    tick();
    ld_a = 1'b0; sp_a = 1'b1;
    checks++; if (q_a !== 4'hD || tc_a !== 1'b0) begin errors++; $display("FAIL up_load got q=%h tc=%b exp q=d tc=0", q_a, tc_a); end
    tick();
    checks++; if (q_a !== 4'hE || tc_a !== 1'b0 || co_a !== 1'b0) begin errors++; $display("FAIL up_e got q=%h tc=%b co=%b exp e 0 0", q_a, tc_a, co_a); end
    tick();
    checks++; if (q_a !== 4'hF || tc_a !== 1'b1 || co_a !== 1'b0) begin errors++; $display("FAIL up_f got q=%h tc=%b co=%b exp f 1 0", q_a, tc_a, co_a); end
    tick();
    checks++; if (q_a !== 4'h0 || tc_a !== 1'b0 || co_a !== 1'b1) begin errors++; $display("FAIL up_wrap got q=%h tc=%b co=%b exp 0 0 1", q_a, tc_a, co_a); end
    tick();
    checks++; if (q_a !== 4'h1 || tc_a !== 1'b0 || co_a !== 1'b0) begin errors++; $display("FAIL up_1 got q=%h tc=%b co=%b exp 1 0 0", q_a, tc_a, co_a); end
    sp_a = 1'b0;
  endtask

  task automatic test_down_wrap();
    up_a = 1'b0; ld_a = 1'b1; d_a = 4'h1; sp_a = 1'b0;
    tick();
    ld_a = 1'b0; sp_a = 1'b1;
    tick();
    checks++; if (q_a !== 4'h0 || tc_a !== 1'b1 || co_a !== 1'b0) begin errors++; $display("FAIL dn_0 got q=%h tc=%b co=%b exp 0 1 0", q_a, tc_a, co_a); end
    sp_a = 1'b0;
    tick();
    checks++; if (q_a !== 4'h0 || tc_a !== 1'b1 || co_a !== 1'b0) begin errors++; $display("FAIL dn_hold got q=%h tc=%b co=%b exp 0 1 0", q_a, tc_a, co_a); end
    sp_a = 1'b1;
    tick();
    checks++; if (q_a !== 4'hF || tc_a !== 1'b0 || co_a !== 1'b1) begin errors++; $display("FAIL dn_wrap got q=%h tc=%b co=%b exp f 0 1", q_a, tc_a, co_a); end
    sp_a = 1'b0;
    tick();
    checks++; if (co_a !== 1'b0) begin errors++; $display("FAIL dn_co_width got %b exp 0", co_a); end
  endtask

  task automatic test_back_to_back();
    up_a = 1'b1; ld_a = 1'b1; d_a = 4'h5; sp_a = 1'b0;
    tick();
    ld_a = 1'b0; sp_a = 1'b1;
    tick();
    checks++; if (q_a !== 4'h6) begin errors++; $display("FAIL dir_up got %h exp %h", q_a, 4'h6); end
    up_a = 1'b0;
    tick();
    checks++; if (q_a !== 4'h5) begin errors++; $display("FAIL dir_down got %h exp %h", q_a, 4'h5); end
    sp_a = 1'b0;
  endtask

  task automatic test_load_priority();
    up_a = 1'b1; ld_a = 1'b1; d_a = 4'hF; sp_a = 1'b0;
    tick();
    checks++; if (q_a !== 4'hF || tc_a !== 1'b1) begin errors++; $display("FAIL ldp_f got q=%h tc=%b exp f 1", q_a, tc_a); end
    d_a = 4'h5; sp_a = 1'b1;
    tick();
    checks++; if (q_a !== 4'h5 || co_a !== 1'b0) begin errors++; $display("FAIL ldp_beats got q=%h co=%b exp 5 0", q_a, co_a); end
    ld_a = 1'b0; sp_a = 1'b0;
  endtask

  task automatic test_oneshot();
    sp_b = 1'b1; ld_b = 1'b0; up_b = 1'b1; d_b = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (q_b !== 4'h0 || run_b !== 1'b0 || tc_b !== 1'b0) begin errors++; $display("FAIL os_idle got q=%h run=%b tc=%b exp 0 0 0", q_b, run_b, tc_b); end
    ld_b = 1'b1; d_b = 4'hE;
    tick();
    ld_b = 1'b0;
    checks++; if (q_b !== 4'hE || run_b !== 1'b1) begin errors++; $display("FAIL os_load got q=%h run=%b exp e 1", q_b, run_b); end
    tick();
    checks++; if (q_b !== 4'hF || tc_b !== 1'b1 || co_b !== 1'b0) begin errors++; $display("FAIL os_f got q=%h tc=%b co=%b exp f 1 0", q_b, tc_b, co_b); end
    tick();
    checks++; if (q_b !== 4'hF || co_b !== 1'b1 || run_b !== 1'b0 || tc_b !== 1'b0) begin errors++; $display("FAIL os_done got q=%h co=%b run=%b tc=%b exp f 1 0 0", q_b, co_b, run_b, tc_b); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (q_b !== 4'hF || co_b !== 1'b0 || run_b !== 1'b0) begin errors++; $display("FAIL os_hold got q=%h co=%b run=%b exp f 0 0", q_b, co_b, run_b); end
    ld_b = 1'b1; d_b = 4'h3; sp_b = 1'b0;
    tick();
    ld_b = 1'b0;
    checks++; if (q_b !== 4'h3 || run_b !== 1'b1) begin errors++; $display("FAIL os_reload got q=%h run=%b exp 3 1", q_b, run_b); end
  endtask

  task automatic test_sclr();
`ifdef CNT_UD_TC_SCLR_EN
    ld_a = 1'b1; d_a = 4'h6; sp_a = 1'b0; up_a = 1'b1;
    tick();
    sclr_a = 1'b1; d_a = 4'hA; sp_a = 1'b1;
    tick();
    checks++; if (q_a !== 4'h0 || co_a !== 1'b0) begin errors++; $display("FAIL sclr got q=%h co=%b exp 0 0", q_a, co_a); end
    sclr_a = 1'b0; ld_a = 1'b0; sp_a = 1'b0;
`endif
  endtask

  initial begin
    cd_a = 1'b1; sp_a = 1'b0; ld_a = 1'b0; up_a = 1'b1; sclr_a = 1'b0; d_a = 4'h0;
    cd_b = 1'b1; sp_b = 1'b0; ld_b = 1'b0; up_b = 1'b1; sclr_b = 1'b0; d_b = 4'h0;
    test_reset();
    test_async_clear();
    test_up_wrap();
    test_down_wrap();
    test_back_to_back();
    test_load_priority();
    test_oneshot();
    test_sclr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
